// File: rtl/avst_stream_arbiter.sv
// -----------------------------------------------------------------------------
// avst_stream_arbiter
//
// Round-robin arbiter sharing one Avalon-ST sink (readyLatency 0) between
// NUM_SRC Avalon-ST sources. One source is granted at a time, its beats are
// forwarded through a registered output stage and tagged with the source
// index on sink_channel.
//
// Configuration macro: AVST_ARB_BURST_EN
//   defined   : a grant is held for up to BURST_LEN beats.
//   undefined : every grant releases after exactly one accepted beat
//               (per-beat interleaving) and no beat counter is built.
//
// Parameters:
//   DATA_WIDTH  beat width in bits
//   NUM_SRC     number of sources (2..16)
//   BURST_LEN   maximum beats per grant (1..256), burst mode only
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   src_valid     per-source valid
//   src_data      source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ready     per-source ready (combinational)
//   sink_ready    downstream ready
//   sink_valid    output beat valid (registered)
//   sink_data     output beat (registered)
//   sink_channel  source index of the output beat (registered)
//   busy          high while a grant is held (registered)
// -----------------------------------------------------------------------------
module avst_stream_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int BURST_LEN  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          sink_ready,
  output logic                          sink_valid,
  output logic [DATA_WIDTH-1:0]         sink_data,
  output logic [$clog2(NUM_SRC)-1:0]    sink_channel,
  output logic                          busy
);

  localparam int CH_W = $clog2(NUM_SRC);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                state_q;
  logic [CH_W-1:0]       ptr_q;
  logic [CH_W-1:0]       gnt_q;
  logic                  busy_q;
  logic                  sink_valid_q;
  logic [DATA_WIDTH-1:0] sink_data_q;
  logic [CH_W-1:0]       sink_channel_q;

  logic                  out_free_s;
  logic                  xfer_s;
  logic                  last_beat_s;
  logic                  pick_found_s;
  logic [CH_W-1:0]       pick_idx_s;

`ifdef AVST_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  logic [CNT_W-1:0]      beat_cnt_q;
`endif

  // First requester strictly after 'last', wrapping; returns {found, index}.
  // Starting after the previous winner gives it the lowest priority.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                            input logic [CH_W-1:0]    last);
    logic            found;
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] cand;
    found = 1'b0;
    idx   = {CH_W{1'b0}};
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = CH_W'((int'(last) + k) % NUM_SRC);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free_s = !sink_valid_q || sink_ready;

  // A source transfer: granted source valid while the output stage is free.
  assign xfer_s = (state_q == ST_GRANT) && src_valid[gnt_q] && out_free_s;

`ifdef AVST_ARB_BURST_EN
  assign last_beat_s = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
`else
  assign last_beat_s = 1'b1;
`endif

  // Round-robin selection from the pointer, evaluated every cycle.
  always_comb begin
    {pick_found_s, pick_idx_s} = rr_pick(src_valid, ptr_q);
  end

  // Ready goes only to the granted source and only when the output can load.
  always_comb begin
    src_ready = {NUM_SRC{1'b0}};
    if ((state_q == ST_GRANT) && out_free_s) begin
      src_ready[gnt_q] = 1'b1;
    end else begin
      src_ready = {NUM_SRC{1'b0}};
    end
  end

  // Grant state machine: arbitration in IDLE, burst/idle release in GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= CH_W'(NUM_SRC - 1);
      gnt_q   <= {CH_W{1'b0}};
      busy_q  <= 1'b0;
`ifdef AVST_ARB_BURST_EN
      beat_cnt_q <= {CNT_W{1'b0}};
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found_s) begin
            gnt_q   <= pick_idx_s;
            ptr_q   <= pick_idx_s;
            state_q <= ST_GRANT;
            busy_q  <= 1'b1;
`ifdef AVST_ARB_BURST_EN
            beat_cnt_q <= {CNT_W{1'b0}};
`endif
          end
        end
        ST_GRANT: begin
          if (!src_valid[gnt_q]) begin
            // Idle release: the granted source has nothing to send.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (xfer_s) begin
`ifdef AVST_ARB_BURST_EN
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
`endif
            if (last_beat_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: load on transfer, clear on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sink_valid_q   <= 1'b0;
      sink_data_q    <= {DATA_WIDTH{1'b0}};
      sink_channel_q <= {CH_W{1'b0}};
    end else if (xfer_s) begin
      sink_valid_q   <= 1'b1;
      sink_data_q    <= src_data[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
      sink_channel_q <= gnt_q;
    end else if (sink_ready) begin
      sink_valid_q   <= 1'b0;
    end
  end

  assign sink_valid   = sink_valid_q;
  assign sink_data    = sink_data_q;
  assign sink_channel = sink_channel_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_avst_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_avst_stream_arbiter
//
// Directed scoreboard bench. Each phase pushes the hand-derived beat sequence
// (channel, {channel, per-source counter}) into a queue; a monitor compares
// every presented output beat with the queue head and pops on acceptance.
// Sources are counter generators whose valid is governed by a beat budget.
// B is the effective beats per grant (BURST_LEN with AVST_ARB_BURST_EN,
// otherwise 1).
// -----------------------------------------------------------------------------
module tb_avst_stream_arbiter;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int BL = 8;
`ifdef AVST_ARB_BURST_EN
  localparam int B = BL;
`else
  localparam int B = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NS-1:0]     src_valid = '0;
  logic [NS*DW-1:0]  src_data = '0;
  logic [NS-1:0]     src_ready;
  logic              sink_ready = 1'b1;
  logic              sink_valid;
  logic [DW-1:0]     sink_data;
  logic [1:0]        sink_channel;
  logic              busy;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            lim[NS] = '{default: 0};
  logic [NS-1:0] hold = '0;
  int            cnt[NS] = '{default: 0};
  int            exp_cnt[NS] = '{default: 0};

  avst_stream_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_SRC    (NS),
    .BURST_LEN  (BL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .sink_ready   (sink_ready),
    .sink_valid   (sink_valid),
    .sink_data    (sink_data),
    .sink_channel (sink_channel),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Counter sources: sample handshake mid-cycle, advance just after the edge.
  initial begin
    logic [NS-1:0] fire;
    forever begin
      @(negedge clk);
      fire = src_valid & src_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NS; i++) begin
        if (fire[i]) begin
          cnt[i] = cnt[i] + 1;
          lim[i] = lim[i] - 1;
        end
        src_valid[i] = (lim[i] > 0) && !hold[i];
        src_data[i*DW +: DW] = {16'(i), 16'(cnt[i])};
      end
    end
  end

  // Monitor: every presented beat must equal the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (sink_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got ch=%0d data=%h, expected no beat",
                   sink_channel, sink_data);
        end else begin
          if (sink_channel !== exp_q[0].ch || sink_data !== exp_q[0].data) begin
            n_err++;
            $display("FAIL beat: got ch=%0d data=%h, expected ch=%0d data=%h",
                     sink_channel, sink_data, exp_q[0].ch, exp_q[0].data);
          end
          if (sink_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  task automatic push_beats(input int ch, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.ch   = 2'(ch);
      b.data = {16'(ch), 16'(exp_cnt[ch])};
      exp_q.push_back(b);
      exp_cnt[ch] = exp_cnt[ch] + 1;
    end
  endtask

  // Grant cadence with all-valid requesters: IDLE cycle then B GRANT cycles.
  task automatic check_pattern(input int n, input bit stop_all);
    for (int c = 1; c <= n; c++) begin
      step();
      if (stop_all && c == n) begin
        for (int i = 0; i < NS; i++) lim[i] = 0;
      end
      @(negedge clk);
      chk("pattern_valid", 64'(sink_valid), 64'((c >= 2) && (((c - 2) % (B + 1)) < B)));
      chk("pattern_busy", 64'(busy), 64'(((c - 1) % (B + 1)) < B));
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (4) step();
  endtask

  initial begin
    int d;
    // Reset with all sources valid: all outputs low.
    for (int i = 0; i < NS; i++) lim[i] = 1000;
    for (int r = 0; r < 3; r++) begin
      step();
      @(negedge clk);
      chk("rst_sink_valid", 64'(sink_valid), 64'd0);
      chk("rst_sink_data", 64'(sink_data), 64'd0);
      chk("rst_sink_channel", 64'(sink_channel), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_src_ready", 64'(src_ready), 64'd0);
    end
    step();
    rst = 1'b0;

    // Round robin 0,1,2,3,0 with one dead cycle per grant.
    for (int g = 0; g < 5; g++) push_beats(g % NS, B);
    check_pattern(5 * (B + 1), 1'b1);
    wait_drain("rr_drain");

    // Backpressure: 5 stalled cycles mid-burst; held beat checked by monitor.
    push_beats(1, B);
    push_beats(2, B);
    step();
    lim[1] = B;
    lim[2] = B;
    step();
    step();
    sink_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_src_ready", 64'(src_ready), 64'd0);
      chk("stall_sink_valid", 64'(sink_valid), 64'd1);
      step();
    end
    sink_ready = 1'b1;
    wait_drain("bp_drain");

    // Idle release: source 1 sends 3 beats then pauses one cycle.
    push_beats(1, (B < 3) ? B : 3);
    push_beats(2, B);
    push_beats(3, B);
    push_beats(0, B);
    push_beats(1, 3 + B - ((B < 3) ? B : 3));
    step();
    lim[1] = 3 + B;
    step();
    lim[0] = B;
    lim[2] = B;
    lim[3] = B;
    step();
    step();
    step();
    hold[1] = 1'b1;
    step();
    hold[1] = 1'b0;
    wait_drain("idle_rel_drain");

    // Single requester: repeated grants to source 3.
    push_beats(3, 3 * B);
    step();
    lim[3] = 3 * B;
    check_pattern(3 * (B + 1), 1'b0);
    wait_drain("single_drain");

    // Reset mid-burst from source 2: the beat captured at the reset edge is lost.
    d = 0;
    for (int c = 1; c <= 4; c++) begin
      if (((c - 1) % (B + 1)) < B) d++;
    end
    push_beats(2, d);
    exp_cnt[2] = exp_cnt[2] + 1;
    push_beats(0, B);
    push_beats(2, B);
    step();
    lim[2] = d + 1 + B;
    repeat (4) step();
    step();
    rst = 1'b1;
    lim[0] = B;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_sink_valid", 64'(sink_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_src_ready", 64'(src_ready), 64'd0);
    wait_drain("rst_mid_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
